// File: rtl/dmem_read_ctrl_pkg.sv
// Shared types and constants for the data-memory read controller.
//   DWORD        : default data word width
//   rdc_state_e  : read-controller FSM states
package dmem_read_ctrl_pkg;

  localparam int unsigned DWORD = 32;

  typedef enum logic [1:0] {
    RDC_IDLE  = 2'd0,
    RDC_ISSUE = 2'd1,
    RDC_WAIT  = 2'd2,
    RDC_DONE  = 2'd3
  } rdc_state_e;

endpackage

// File: rtl/dmem_read_ctrl_if.sv
// Core-side load handshake plus memory read bus for dmem_read_ctrl.
//   rd_req/rd_addr/flush  : core -> controller
//   stall/rd_data/rd_valid: controller -> core
//   mem_addr/mem_re       : controller -> memory
//   mem_rdata             : memory -> controller
// master: the controller's view; slave: the environment (core + memory).
interface dmem_read_ctrl_if
  import dmem_read_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = DWORD,
  parameter int unsigned AWIDTH = 32
);
  logic              rd_req;
  logic [AWIDTH-1:0] rd_addr;
  logic              flush;
  logic              stall;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_valid;
  logic [AWIDTH-1:0] mem_addr;
  logic              mem_re;
  logic [WIDTH-1:0]  mem_rdata;

  modport master (
    input  rd_req, rd_addr, flush, mem_rdata,
    output stall, rd_data, rd_valid, mem_addr, mem_re
  );

  modport slave (
    output rd_req, rd_addr, flush, mem_rdata,
    input  stall, rd_data, rd_valid, mem_addr, mem_re
  );
endinterface

// File: rtl/rd_latency_counter.sv
// Wait-state counter for the read controller.
//   clk, rst    : clock, synchronous active-high reset
//   load_i      : load load_val_i (has priority over decrement)
//   load_val_i  : reload value
//   dec_i       : decrement request; ignored when already zero
//   zero_o      : counter is zero
module rd_latency_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);
endmodule

// File: rtl/dmem_read_ctrl.sv
// Read-side controller between the mMIPS memory stage and a fixed-latency
// data memory. Accepts a load, stalls the core while it is in flight,
// strobes the memory once, captures the word after LATENCY cycles and
// presents it with a one-cycle rd_valid pulse.
//   clk, rst : clock, synchronous active-high reset
//   bus      : dmem_read_ctrl_if.master (core handshake + memory bus)
module dmem_read_ctrl
  import dmem_read_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = DWORD,
  parameter int unsigned AWIDTH  = 32,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned CNT_W   = 4
) (
  input logic                clk,
  input logic                rst,
  dmem_read_ctrl_if.master   bus
);
  rdc_state_e        state_q, state_d;
  logic [AWIDTH-1:0] mem_addr_q;
  logic [WIDTH-1:0]  rd_data_q;

  logic accept;
  logic capture;
  logic stall_c;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  rd_latency_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (CNT_W'(LATENCY - 1)),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    capture  = 1'b0;
    stall_c  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      RDC_IDLE, RDC_DONE: begin
        // DONE doubles as an accept slot so back-to-back loads leave no gap.
        if (bus.rd_req && !bus.flush) begin
          accept  = 1'b1;
          stall_c = 1'b1;
          state_d = RDC_ISSUE;
        end else begin
          state_d = RDC_IDLE;
        end
      end
      RDC_ISSUE: begin
        if (bus.flush) begin
          state_d = RDC_IDLE;
        end else begin
          stall_c  = 1'b1;
          cnt_load = 1'b1;
          state_d  = RDC_WAIT;
        end
      end
      RDC_WAIT: begin
        if (bus.flush) begin
          state_d = RDC_IDLE;
        end else begin
          stall_c = 1'b1;
          if (cnt_zero) begin
            capture = 1'b1;
            state_d = RDC_DONE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      default: state_d = RDC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RDC_IDLE;
      mem_addr_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mem_addr_q <= bus.rd_addr;
      end
      if (capture) begin
        rd_data_q <= bus.mem_rdata;
      end
    end
  end

  // Reset outranks the combinational stall path so the core is never held during reset.
  assign bus.stall    = stall_c && !rst;
  assign bus.mem_re   = (state_q == RDC_ISSUE);
  assign bus.rd_valid = (state_q == RDC_DONE);
  assign bus.mem_addr = mem_addr_q;
  assign bus.rd_data  = rd_data_q;
endmodule
